if_stage_pc_ctrl: RTL and testbench
===================================

// Module: if_stage_pc_ctrl
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipeline: owns the PC register, selects the next PC and drives the IF/ID register.
//  Consumes the taken/not-taken decision produced by the ID-stage branch comparator, plus the jump and jr targets from decode.
//  Redirects fetch, flushes the wrong-path instruction in IF/ID and holds everything on a load-use stall.
//  Also keeps saturating redirect/stall counters for performance debug.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (bits [1:0] must be 0)
//  NOP_INSTR 32'h0000_0000  instruction word inserted into IF/ID on flush/bubble
//  CNT_W     16             width of each performance counter
// PORTS
//  i_clk             in   1      single clock, rising edge
//  i_rst             in   1      synchronous, active-high reset
//  i_stall           in   1      load-use stall from hazard unit; hold PC and IF/ID
//  i_branch          in   1      branch taken (ID-stage comparator result)
//  i_branch_target   in   32     branch target computed in ID
//  i_jump            in   1      j/jal decoded in ID
//  i_jump_target     in   32     {pc_plus4[31:28], instr_index, 2'b00}
//  i_jr              in   1      jr/jalr decoded in ID
//  i_jr_target       in   32     forwarded rs value
//  i_imem_instr      in   32     instruction memory read data for o_pc (combinational read)
//  o_pc              out  32     current fetch PC, to instruction memory
//  o_ifid_instr      out  32     IF/ID instruction
//  o_ifid_pc_plus4   out  32     IF/ID PC+4
//  o_ifid_valid      out  1      IF/ID holds a real (non-bubble) instruction
//  o_redirect_cnt    out  CNT_W  count of cycles in which fetch was redirected
//  o_stall_cnt       out  CNT_W  count of stalled cycles
// BEHAVIOUR
//  Reset (i_rst=1 at posedge): o_pc=RESET_PC, o_ifid_instr=NOP_INSTR, o_ifid_pc_plus4=0, o_ifid_valid=0, both counters=0, state=BOOT.
//  Reset has priority over every other input; it aborts any redirect/stall in progress with no residual effect.
//  FSM: BOOT -> RUN unconditionally after one cycle. In BOOT, PC is held and IF/ID is loaded with a bubble (valid=0).
//   RUN is the steady state; there is no other exit except reset.
//  Redirect select (RUN, no stall): i_branch > i_jr > i_jump; a lower-priority request is ignored when a higher one is asserted.
//  Next PC (RUN): stall -> hold; redirect -> selected target with bits [1:0] forced to 2'b00; else o_pc+4.
//   Addition is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
//  IF/ID (RUN): stall -> all three fields hold.
//   Redirect -> instr=NOP_INSTR, valid=0, pc_plus4=o_pc+4 (flushes the wrong-path instruction).
//   Else -> instr=i_imem_instr, pc_plus4=o_pc+4, valid=1.
//  Stall and redirect asserted together: stall wins. Nothing is redirected or counted as a redirect.
//   The ID stage re-presents the branch in the following cycle.
//  Latency: the redirect target appears on o_pc one cycle after i_branch/i_jump/i_jr is sampled.
//   Exactly one bubble follows a taken branch or jump (no delay slot).
//  Counters: o_redirect_cnt +1 per RUN cycle with an accepted redirect; o_stall_cnt +1 per RUN cycle with i_stall=1.
//   Both saturate at all-ones (no wrap). Neither counts in BOOT.
//  All outputs are registered. There are no combinational paths from inputs to outputs.
// TESTING
//  1. Reset, then 4 idle cycles, imem returns 0x20080001.. -> o_pc 0,0,4,8,C; ifid_valid 0,0,1,1,1; ifid_pc_plus4 0x4 then 0x8.
//  2. At o_pc=0x10, i_branch=1, target=0x40 -> next o_pc=0x40, ifid_valid=0, ifid_instr=NOP; next cycle valid=1, pc_plus4=0x44; redirect_cnt=1.
//  3. i_stall=1 for 2 cycles at o_pc=0x20 -> o_pc and IF/ID frozen 2 cycles, stall_cnt=2; with i_branch=1 concurrently no redirect occurs.
//  4. i_branch=1, i_jr=1, i_jump=1 together, targets 0x100/0x203/0x300 -> o_pc=0x100; then i_jr alone with target 0x203 -> o_pc=0x200.
//  5. Force o_pc=0xFFFF_FFFC via jr -> next o_pc=0x0, ifid_pc_plus4=0x0; CNT_W=4, 20 stall cycles -> stall_cnt sticks at 0xF.
//  6. Assert i_rst mid-stall with a branch pending -> next cycle all outputs equal reset values, state BOOT; the branch has no effect.

Source files
------------

// File: rtl/if_stage_pc_ctrl.sv
// rtl/if_stage_pc_ctrl.sv - IF stage: PC register, next-PC select, IF/ID register, perf counters
module if_stage_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_branch,
  input  logic [31:0]      i_branch_target,
  input  logic             i_jump,
  input  logic [31:0]      i_jump_target,
  input  logic             i_jr,
  input  logic [31:0]      i_jr_target,
  input  logic [31:0]      i_imem_instr,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_ifid_instr,
  output logic [31:0]      o_ifid_pc_plus4,
  output logic             o_ifid_valid,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;

  assign pc_plus4 = o_pc + 32'd4;

  // Branch beats jr beats jump; the selected target is always word aligned.
  always_comb begin
    redirect        = i_branch | i_jr | i_jump;
    redirect_target = i_jump_target;
    if (i_branch)
      redirect_target = i_branch_target;
    else if (i_jr)
      redirect_target = i_jr_target;
    redirect_target[1:0] = 2'b00;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= BOOT;
      o_pc            <= RESET_PC;
      o_ifid_instr    <= NOP_INSTR;
      o_ifid_pc_plus4 <= 32'd0;
      o_ifid_valid    <= 1'b0;
      o_redirect_cnt  <= '0;
      o_stall_cnt     <= '0;
    end else begin
      case (state)
        BOOT: begin
          state        <= RUN;
          o_ifid_instr <= NOP_INSTR;
          o_ifid_valid <= 1'b0;
        end
        RUN: begin
          // A stall freezes PC and IF/ID and swallows any concurrent redirect.
          if (i_stall) begin
            if (o_stall_cnt != CNT_MAX)
              o_stall_cnt <= o_stall_cnt + CNT_W'(1);
          end else if (redirect) begin
            o_pc            <= redirect_target;
            o_ifid_instr    <= NOP_INSTR;
            o_ifid_pc_plus4 <= pc_plus4;
            o_ifid_valid    <= 1'b0;
            if (o_redirect_cnt != CNT_MAX)
              o_redirect_cnt <= o_redirect_cnt + CNT_W'(1);
          end else begin
            o_pc            <= pc_plus4;
            o_ifid_instr    <= i_imem_instr;
            o_ifid_pc_plus4 <= pc_plus4;
            o_ifid_valid    <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage_pc_ctrl.sv
// tb/tb_if_stage_pc_ctrl.sv - self-checking bench for if_stage_pc_ctrl
module tb_if_stage_pc_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0, stall = 1'b0, branch = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0]   branch_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0]   imem_instr, pc, ifid_instr, ifid_pc_plus4;
  logic          ifid_valid;
  logic [CW-1:0] redirect_cnt, stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2008_0001 + a;
  endfunction

  assign imem_instr = mem(pc);

  if_stage_pc_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_branch(branch), .i_branch_target(branch_target),
    .i_jump(jump), .i_jump_target(jump_target),
    .i_jr(jr), .i_jr_target(jr_target),
    .i_imem_instr(imem_instr),
    .o_pc(pc), .o_ifid_instr(ifid_instr), .o_ifid_pc_plus4(ifid_pc_plus4),
    .o_ifid_valid(ifid_valid), .o_redirect_cnt(redirect_cnt), .o_stall_cnt(stall_cnt)
  );

  // Reference model: what the fetch stage holds after each clock edge.
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_boot;
  int          m_rc, m_sc;

  always @(posedge clk) begin
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_p4 = 32'h0; m_valid = 1'b0;
      m_rc = 0; m_sc = 0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0; m_instr = NOP; m_valid = 1'b0;
    end else if (stall) begin
      m_sc = (m_sc < 15) ? m_sc + 1 : 15;
    end else if (branch || jr || jump) begin
      tgt = branch ? branch_target : (jr ? jr_target : jump_target);
      m_p4 = m_pc + 32'd4;
      m_instr = NOP; m_valid = 1'b0;
      m_rc = (m_rc < 15) ? m_rc + 1 : 15;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      m_instr = mem(m_pc);
      m_p4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc_plus4", ifid_pc_plus4, m_p4);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      chk("redirect_cnt", {28'd0, redirect_cnt}, m_rc);
      chk("stall_cnt", {28'd0, stall_cnt}, m_sc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch = 0; jump = 0; jr = 0;
  endtask

  initial begin
    idle();
    rst = 1; tick();
    chk_en = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_cnt", {24'd0, redirect_cnt, stall_cnt}, 32'd0);
    rst = 0; tick();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("run1_pc", pc, 32'h4);
    chk("run1_p4", ifid_pc_plus4, 32'h4);
    chk("run1_instr", ifid_instr, 32'h2008_0001);
    tick();
    chk("run2_pc", pc, 32'h8);
    chk("run2_p4", ifid_pc_plus4, 32'h8);
    tick(); tick();
    chk("run4_pc", pc, 32'h10);
    // taken branch at 0x10 -> 0x40, one bubble
    branch = 1; branch_target = 32'h40; tick();
    chk("br_pc", pc, 32'h40);
    chk("br_valid", {31'd0, ifid_valid}, 32'd0);
    chk("br_instr", ifid_instr, NOP);
    chk("br_rc", {28'd0, redirect_cnt}, 32'd1);
    idle(); tick();
    chk("br_next_valid", {31'd0, ifid_valid}, 32'd1);
    chk("br_next_p4", ifid_pc_plus4, 32'h44);
    // stall with concurrent branch at 0x20
    jump = 1; jump_target = 32'h20; tick();
    chk("j_pc", pc, 32'h20);
    idle(); stall = 1; branch = 1; branch_target = 32'h80; tick(); tick();
    chk("st_pc", pc, 32'h20);
    chk("st_valid", {31'd0, ifid_valid}, 32'd0);
    chk("st_sc", {28'd0, stall_cnt}, 32'd2);
    chk("st_rc", {28'd0, redirect_cnt}, 32'd2);
    idle(); tick();
    chk("st_after_pc", pc, 32'h24);
    // priority branch > jr > jump, and target alignment
    branch = 1; jr = 1; jump = 1;
    branch_target = 32'h100; jr_target = 32'h203; jump_target = 32'h300; tick();
    chk("prio_pc", pc, 32'h100);
    idle(); jr = 1; tick();
    chk("jr_align_pc", pc, 32'h200);
    // PC wrap
    jr_target = 32'hFFFF_FFFF; tick();
    chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    idle(); tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_p4", ifid_pc_plus4, 32'h0);
    chk("wrap_instr", ifid_instr, 32'h2007_FFFD);
    stall = 1;
    repeat (20) tick();
    chk("sat_sc", {28'd0, stall_cnt}, 32'hF);
    // reset mid-stall with branch pending
    branch = 1; branch_target = 32'h500; tick();
    rst = 1; tick();
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst2_cnt", {24'd0, redirect_cnt, stall_cnt}, 32'd0);
    chk("rst2_p4", ifid_pc_plus4, 32'h0);
    rst = 0; tick();
    chk("rst2_boot_pc", pc, 32'h0);
    chk("rst2_boot_sc", {28'd0, stall_cnt}, 32'd0);
    idle();
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 5) == 0);
      jr     = ($urandom_range(0, 5) == 0);
      jump   = ($urandom_range(0, 5) == 0);
      branch_target = $urandom();
      jr_target     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom();
      jump_target   = $urandom();
      tick();
    end
    idle(); rst = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
